dls_fault_manager: RTL
======================

// Module: dls_fault_manager
// PURPOSE
// Downstream consumer of the dual-lockstep VGA comparator. Takes the per-signal mismatch vector,
// filters transient disagreements with a persistence counter and latches confirmed faults.
// Counts faults and transients, and raises an interrupt. After repeated faults it locks the
// display into a safe (blanked) state. Status and control registers are on an AHB-Lite slave port.
// PARAMETERS
// PERSIST_CYCLES  3   consecutive mismatch cycles needed to confirm a fault (1..255)
// MAX_FAULTS      4   confirmed-fault count that forces LOCKED (1..2^CNT_W-1)
// CNT_W           16  width of the fault and transient counters (saturating, <=32)
// PORTS
// HCLK        in   1   clock; everything is synchronous to the rising edge
// HRESET      in   1   asynchronous, active-high reset
// MISMATCH    in   5   comparator mismatch per signal:
//                      [0]HSYNC [1]VSYNC [2]RGB [3]HRDATA [4]HREADYOUT
// HSEL        in   1   AHB slave select
// HADDR       in   32  AHB address; only [3:2] are decoded
// HTRANS      in   2   AHB transfer type; a transfer is valid when HTRANS[1]=1
// HWRITE      in   1   AHB write strobe
// HWDATA      in   32  AHB write data, sampled in the data phase
// HREADY      in   1   AHB bus ready
// HRDATA      out  32  AHB read data
// HREADYOUT   out  1   constant 1; this slave never inserts wait states
// DLS_FAULT   out  1   high in FAULT or LOCKED
// DLS_IRQ     out  1   level interrupt = irq_pend & irq_en
// SAFE_BLANK  out  1   high in LOCKED only; requests RGB blanking downstream
// BEHAVIOUR
// - Reset: state OK; run count, counters, cause, irq_pend and irq_en all 0.
//   Reset output values: HRDATA 0, HREADYOUT 1, DLS_FAULT 0, DLS_IRQ 0, SAFE_BLANK 0.
// - any = |MISMATCH. All state outputs are registered, so they change one cycle after the
//   causing edge.
// - Transfer qualification: a transfer is valid when HSEL & HREADY & HTRANS[1].
// - Address phase: a valid transfer registers the address and the write flag.
// - Data phase (next cycle):
//   - write: updates CTRL from HWDATA at the end of that cycle.
//   - read: HRDATA = selected register; otherwise HRDATA = 0.
// - Register map:
//   - 0x0 STATUS RO: [1:0] state (0 OK, 1 SUSPECT, 2 FAULT, 3 LOCKED), [6:2] cause,
//     [7] irq_pend, [8] irq_en, other bits 0.
//   - 0x4 FAULT_CNT RO: zero-extended. 0x8 TRANS_CNT RO: zero-extended.
//   - 0xC CTRL: write [0] CLEAR (pulse, not stored), [1] irq_en (stored); reads return [1]=irq_en.
// - FSM:
//   - OK & any:
//     - PERSIST_CYCLES==1: go to FAULT.
//     - otherwise: go to SUSPECT with run=1, cause=MISMATCH.
//   - SUSPECT & any:
//     - cause |= MISMATCH, run++.
//     - when run reaches PERSIST_CYCLES, take the fault-entry action.
//   - SUSPECT & !any: go to OK; TRANS_CNT++ (saturating); cause is cleared.
//   - Fault entry:
//     - FAULT_CNT++ (saturating); irq_pend=1.
//     - if the new FAULT_CNT >= MAX_FAULTS go to LOCKED, else go to FAULT.
//   - FAULT & CLEAR & !any: go to OK; irq_pend=0; cause=0.
//   - FAULT & CLEAR & any: stay in FAULT; irq_pend=0.
//   - LOCKED: exits only on HRESET. CLEAR clears irq_pend only.
// - Simultaneous events:
//   - CLEAR in the same cycle as fault entry: entry wins and irq_pend ends at 1.
//   - CLEAR while in OK or SUSPECT: no effect on state or counters.
// - Counters hold at all-ones when saturated and never wrap.
// - HRESET mid-operation aborts everything immediately. The next cycle after deassertion
//   starts in OK.
// TESTING
// Defaults throughout: PERSIST_CYCLES=3, MAX_FAULTS=4.
// 1. MISMATCH=5'b00100 for 2 cycles, then 0 -> state returns to OK, TRANS_CNT=1,
//    DLS_FAULT stays 0.
// 2. Write CTRL=0x2; then MISMATCH=5'b00001 for 3 cycles ->
//    - DLS_FAULT=1 one cycle after the 3rd mismatch cycle, FAULT_CNT=1;
//    - STATUS reads 0x186 (state 2, cause 00001, irq_pend, irq_en); DLS_IRQ=1.
// 3. In FAULT, write CTRL=0x3 with MISMATCH=0 -> state OK, DLS_FAULT=0, DLS_IRQ=0.
//    Repeat the write with MISMATCH held nonzero -> state stays FAULT, irq_pend=0.
// 4. Four confirmed faults, each cleared -> after the 4th, state LOCKED, SAFE_BLANK=1.
//    A CLEAR write leaves SAFE_BLANK=1. Pulse HRESET -> all outputs 0, FAULT_CNT=0.
// 5. CLEAR write landing in the exact cycle the 3rd mismatch confirms a fault ->
//    state FAULT, irq_pend=1.
// 6. Back-to-back AHB read 0x4 then write 0xC -> HRDATA valid in the read data phase,
//    HREADYOUT=1 throughout, CTRL updated.

Source files
------------

// File: rtl/dls_fault_manager.sv
// dls_fault_manager: filters lockstep mismatches, latches faults, counts events, AHB-Lite status/control
module dls_fault_manager #(
  parameter int PERSIST_CYCLES = 3,
  parameter int MAX_FAULTS     = 4,
  parameter int CNT_W          = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [4:0]  MISMATCH,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        DLS_FAULT,
  output logic        DLS_IRQ,
  output logic        SAFE_BLANK
);
  typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_FAULT, ST_LOCKED} state_e;
  state_e           state_q, state_d;
  logic [7:0]       run_q, run_d;
  logic [4:0]       cause_q, cause_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d, tcnt_q, tcnt_d, fcnt_inc;
  logic             pend_q, pend_d, en_q, en_d;
  logic             dph_v_q, dph_w_q;
  logic [1:0]       dph_a_q;
  logic             any, ctrl_wr, clear, enter;
  logic             unused_bits;
  assign any         = |MISMATCH;
  assign ctrl_wr     = dph_v_q & dph_w_q & (dph_a_q == 2'd3);
  assign clear       = ctrl_wr & HWDATA[0];
  assign fcnt_inc    = &fcnt_q ? fcnt_q : fcnt_q + CNT_W'(1);
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA[31:2], HTRANS[0]};
  // AHB address phase capture for the following data phase
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dph_v_q <= 1'b0;
      dph_w_q <= 1'b0;
      dph_a_q <= 2'd0;
    end else begin
      dph_v_q <= HSEL & HREADY & HTRANS[1];
      dph_w_q <= HWRITE;
      dph_a_q <= HADDR[3:2];
    end
  end
  // fault-manager state and counters
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= ST_OK;
      run_q   <= '0;
      cause_q <= '0;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cause_q <= cause_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
    end
  end
  // next state: persistence filtering, fault entry (which overrides a same-cycle CLEAR), clearing
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cause_d = cause_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    pend_d  = pend_q;
    en_d    = ctrl_wr ? HWDATA[1] : en_q;
    enter   = 1'b0;
    case (state_q)
      ST_OK: if (any) begin
        state_d = ST_SUSPECT;
        run_d   = 8'd1;
        cause_d = MISMATCH;
        enter   = (PERSIST_CYCLES == 1);
      end
      ST_SUSPECT: if (any) begin
        run_d   = run_q + 8'd1;
        cause_d = cause_q | MISMATCH;
        enter   = (run_q + 8'd1 == 8'(PERSIST_CYCLES));
      end else begin
        state_d = ST_OK;
        run_d   = '0;
        cause_d = '0;
        tcnt_d  = &tcnt_q ? tcnt_q : tcnt_q + CNT_W'(1);
      end
      ST_FAULT: if (clear) begin
        pend_d  = 1'b0;
        state_d = any ? ST_FAULT : ST_OK;
        cause_d = any ? cause_q : 5'd0;
      end
      default: pend_d = clear ? 1'b0 : pend_q;
    endcase
    if (enter) begin
      fcnt_d  = fcnt_inc;
      pend_d  = 1'b1;
      run_d   = '0;
      state_d = (fcnt_inc >= CNT_W'(MAX_FAULTS)) ? ST_LOCKED : ST_FAULT;
    end
  end
  // outputs decoded from registered state; read data only in a read data phase
  always_comb begin
    HREADYOUT  = 1'b1;
    DLS_FAULT  = state_q[1];
    SAFE_BLANK = (state_q == ST_LOCKED);
    DLS_IRQ    = pend_q & en_q;
    HRDATA     = !(dph_v_q & !dph_w_q) ? 32'd0 :
                 (dph_a_q == 2'd0) ? {23'd0, en_q, pend_q, cause_q, state_q} :
                 (dph_a_q == 2'd1) ? 32'(fcnt_q) :
                 (dph_a_q == 2'd2) ? 32'(tcnt_q) : {30'd0, en_q, 1'b0};
  end
endmodule
